// File: rtl/arb_defs.sv
// Shared definitions for the eight-way bus arbiter: sizes, FSM encoding, helpers.
package arb_defs;

    localparam int unsigned NREQ   = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned HOLD_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // One-hot expansion of a requester index into a grant vector.
    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: rotate req so last+1 sits at bit 0,
// priority-encode the lowest set bit, then un-rotate back to a real index.
module rr_pick8
    import arb_defs::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] off;
    logic [NREQ-1:0]  rot;

    assign base = last + IDX_W'(1);
    assign any  = |req;
    assign idx  = base + off;

    // Rotate so that requester last+1 lands in bit 0 (indices wrap mod 8).
    always_comb begin
        rot = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            rot[i] = req[base + IDX_W'(i)];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        off = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_8.sv
// Round-robin owner of the internal bus: grant, bounded hold, one-cycle gap.
module bus_arbiter_8
    import arb_defs::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]  gnt_id_q, gnt_id_d;
    logic              gnt_valid_q, gnt_valid_d;
    logic              timeout_q, timeout_d;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic              owner_req;
    logic              hold_done;

    rr_pick8 u_pick (
        .req  (req),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign owner_req = req[gnt_id_q];
    assign hold_done = (cnt_q == HOLD_W'(MAX_HOLD - 1));

    // State and output registers; reset leaves requester 0 at top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= IDX_W'(NREQ - 1);
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state: grant when enabled and someone asks, leave BUSY on release or hold limit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (en && pick_any) state_d = BUSY;
            BUSY: if (!owner_req || hold_done) state_d = GAP;
            GAP:  state_d = (en && pick_any) ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values derived from the state transition.
    always_comb begin
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        if (state_q != BUSY && state_d == BUSY) begin
            cnt_d       = '0;
            last_d      = pick_idx;
            gnt_d       = onehot(pick_idx);
            gnt_id_d    = pick_idx;
            gnt_valid_d = 1'b1;
        end else if (state_q == BUSY && state_d == GAP) begin
            cnt_d       = '0;
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            timeout_d   = owner_req;   // still requesting means the hold limit fired
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + HOLD_W'(1);
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Scoreboard bench for bus_arbiter_8 (MAX_HOLD=4): stimulus pushes expected
// grants, a negedge monitor pops and checks each grant as it appears.
module tb_bus_arbiter_8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] g;
        logic [2:0] id;
        int         len;   // -1: don't care
        logic       to;
        int         gap;   // -1: don't care
    } rec_t;

    rec_t q[$];

    bus_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] g, input logic [2:0] id, input int len,
                        input logic to, input int gap);
        rec_t r;
        r.g = g; r.id = id; r.len = len; r.to = to; r.gap = gap;
        q.push_back(r);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor state
    rec_t cur;
    bit   active    = 1'b0;
    bit   gap_known = 1'b0;
    int   len_cnt   = 0;
    int   gap_cnt   = 0;

    always @(negedge clk) begin
        if (rst) begin
            active    = 1'b0;
            gap_known = 1'b0;
        end else begin
            chk("valid_vs_gnt", 32'(gnt_valid), 32'(gnt != 8'h00));
            if (!gnt_valid) chk("id_zero_when_idle", 32'(gnt_id), 32'd0);
            if (gnt_valid) begin
                if (!active) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_grant: got gnt 0x%0h expected none at %0t", gnt, $time);
                        cur.g = gnt; cur.id = gnt_id; cur.len = -1; cur.to = 1'b0; cur.gap = -1;
                    end else begin
                        cur = q.pop_front();
                        chk("grant_onehot", 32'(gnt), 32'(cur.g));
                        chk("grant_id", 32'(gnt_id), 32'(cur.id));
                        if (cur.gap >= 0 && gap_known)
                            chk("gap_cycles", 32'(gap_cnt), 32'(cur.gap));
                    end
                    active  = 1'b1;
                    len_cnt = 1;
                end else begin
                    len_cnt++;
                    chk("grant_stable", 32'(gnt), 32'(cur.g));
                end
                chk("timeout_low_busy", 32'(timeout), 32'd0);
            end else begin
                if (active) begin
                    if (cur.len >= 0) chk("hold_length", 32'(len_cnt), 32'(cur.len));
                    chk("timeout_pulse", 32'(timeout), 32'(cur.to));
                    active    = 1'b0;
                    gap_cnt   = 1;
                    gap_known = 1'b1;
                end else begin
                    chk("timeout_low_idle", 32'(timeout), 32'd0);
                    gap_cnt++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset with all requesting, then 0 then 1 after one gap
        rst = 1'b1; en = 1'b1; req = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        push(8'h01, 3'd0, 2, 1'b0, -1);
        push(8'h02, 3'd1, 1, 1'b0, 1);
        rst = 1'b0;
        cyc(1);
        chk("first_grant_latency", 32'(gnt), 32'h01);
        cyc(1);
        req = 8'hFE;
        cyc(2);
        req = 8'h00;
        cyc(4);

        // T2: req 0 and 7, 3-cycle ownerships -> 0,7,0,7
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        req = 8'h81;
        push(8'h01, 3'd0, 3, 1'b0, -1);
        push(8'h80, 3'd7, 3, 1'b0, 1);
        push(8'h01, 3'd0, 3, 1'b0, 1);
        push(8'h80, 3'd7, 3, 1'b0, 1);
        cyc(1);
        for (int k = 0; k < 4; k++) begin
            cyc(2);
            req = (k % 2 == 0) ? 8'h80 : 8'h01;
            cyc(1);
            req = (k == 3) ? 8'h00 : 8'h81;
            cyc(1);
        end
        cyc(3);

        // T3: lone requester 5 times out, is re-granted, then releases
        push(8'h20, 3'd5, 4, 1'b1, -1);
        push(8'h20, 3'd5, 4, 1'b1, 1);
        push(8'h20, 3'd5, 2, 1'b0, 1);
        req = 8'h20;
        cyc(1);
        cyc(11);
        req = 8'h00;
        cyc(4);

        // T4: requesters 2 and 3 alternate on hold-limit timeouts
        push(8'h04, 3'd2, 4, 1'b1, -1);
        push(8'h08, 3'd3, 4, 1'b1, 1);
        push(8'h04, 3'd2, 4, 1'b1, 1);
        req = 8'h0C;
        cyc(1);
        cyc(14);
        req = 8'h00;
        cyc(4);

        // T5: enable gating; dropping en mid-grant does not revoke it
        en = 1'b0; req = 8'h10;
        cyc(3);
        chk("en_low_blocks", 32'(gnt), 32'd0);
        push(8'h10, 3'd4, 2, 1'b0, -1);
        en = 1'b1;
        cyc(1);
        chk("en_grant_latency", 32'(gnt), 32'h10);
        en = 1'b0;
        cyc(1);
        chk("en_low_keeps_grant", 32'(gnt), 32'h10);
        req = 8'h00;
        cyc(3);
        req = 8'h10;
        cyc(3);
        chk("parked_idle", 32'(gnt_valid), 32'd0);

        // T6: asynchronous reset mid-grant, then priority restarts at 0
        push(8'h10, 3'd4, -1, 1'b0, -1);
        en = 1'b1;
        cyc(1);
        cyc(1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", 32'(gnt), 32'd0);
        chk("async_rst_valid", 32'(gnt_valid), 32'd0);
        chk("async_rst_id", 32'(gnt_id), 32'd0);
        chk("async_rst_timeout", 32'(timeout), 32'd0);
        push(8'h04, 3'd2, 2, 1'b0, -1);
        @(posedge clk);
        #1;
        req = 8'h0C;
        rst = 1'b0;
        cyc(1);
        cyc(1);
        req = 8'h00;
        cyc(5);

        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        chk("no_open_grant", 32'(active), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
